// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the dmem responder: request-type encodings, MMIO
// window geometry and the byte offsets of every MMIO register.
package dmem_mmio_pkg;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  // MMIO window is 256 bytes; the base must be aligned to it.
  localparam int unsigned MMIO_WIN_BYTES = 256;
  localparam int unsigned MMIO_WIN_BITS  = $clog2(MMIO_WIN_BYTES);

  localparam logic [7:0] OFF_IN0  = 8'h00;
  localparam logic [7:0] OFF_IN1  = 8'h04;
  localparam logic [7:0] OFF_IN2  = 8'h08;
  localparam logic [7:0] OFF_OUT0 = 8'h10;
  localparam logic [7:0] OFF_OUT1 = 8'h14;
  localparam logic [7:0] OFF_OUT2 = 8'h18;
  localparam logic [7:0] OFF_CCNT = 8'h20;
  localparam logic [7:0] OFF_WCNT = 8'h24;

endpackage

// File: rtl/dmem_mmio_responder_sync2_reg.sv
// sync2_reg: parameterised-width two-flop synchroniser, async active-high
// reset to zero.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset
//   d   - asynchronous input
//   q   - synchronised output (d as sampled two posedges earlier)
module sync2_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: responder end of the core's data-memory port.
// Word-addressed RAM (2**ADDR_W words, not reset, aliases on upper address
// bits) plus a 256-byte MMIO window at MMIO_BASE holding synchronised
// inputs, three output registers and optional performance counters.
// Reads are combinational; writes commit on the posedge ending the request.
// Optional feature macro: DMEM_MMIO_PERF_EN (cycle/write counters at 0x20/0x24).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   dmemreq_val/type    - request valid, 0 = read / 1 = write
//   dmemreq_addr/wdata  - byte address ([1:0] ignored), write data
//   dmemresp_rdata      - read data, same cycle; 0 when idle or writing
//   in0..in2            - asynchronous external inputs
//   out0..out2          - MMIO output registers
module dmem_mmio_responder
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_rdata,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [31:0] out2
);

  logic [31:0]       ram [1 << ADDR_W];
  logic [ADDR_W-1:0] ram_idx;
  logic [7:0]        mmio_off;
  logic              is_mmio;
  logic              is_rd;
  logic              is_wr;
  logic              wr_ram;
  logic              wr_out0;
  logic              wr_out1;
  logic              wr_out2;
  logic [31:0]       in0_s;
  logic [31:0]       in1_s;
  logic [31:0]       in2_s;
  logic              unused_addr_lsbs;

  // Byte-lane bits play no part in decode.
  assign unused_addr_lsbs = ^dmemreq_addr[1:0];

  assign is_mmio  = (dmemreq_addr[31:MMIO_WIN_BITS] == MMIO_BASE[31:MMIO_WIN_BITS]);
  assign mmio_off = {dmemreq_addr[7:2], 2'b00};
  assign ram_idx  = dmemreq_addr[ADDR_W+1:2];
  assign is_rd    = dmemreq_val && (dmemreq_type == REQ_READ);
  assign is_wr    = dmemreq_val && (dmemreq_type == REQ_WRITE);

  assign wr_ram   = is_wr && !is_mmio;
  assign wr_out0  = is_wr && is_mmio && (mmio_off == OFF_OUT0);
  assign wr_out1  = is_wr && is_mmio && (mmio_off == OFF_OUT1);
  assign wr_out2  = is_wr && is_mmio && (mmio_off == OFF_OUT2);

  sync2_reg #(.WIDTH(32)) u_sync_in0 (.clk(clk), .rst(rst), .d(in0), .q(in0_s));
  sync2_reg #(.WIDTH(32)) u_sync_in1 (.clk(clk), .rst(rst), .d(in1), .q(in1_s));
  sync2_reg #(.WIDTH(32)) u_sync_in2 (.clk(clk), .rst(rst), .d(in2), .q(in2_s));

  // RAM has no reset; the explicit rst gate drops a write issued while
  // reset is asserted.
  always_ff @(posedge clk) begin
    if (wr_ram && !rst) begin
      ram[ram_idx] <= dmemreq_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0 <= '0;
      out1 <= '0;
      out2 <= '0;
    end else begin
      if (wr_out0) out0 <= dmemreq_wdata;
      if (wr_out1) out1 <= dmemreq_wdata;
      if (wr_out2) out2 <= dmemreq_wdata;
    end
  end

`ifdef DMEM_MMIO_PERF_EN
  logic [31:0] cyc_cnt;
  logic [31:0] wr_cnt;
  logic        wr_accept;

  // Dropped writes (RO or unmapped MMIO offsets) are not counted.
  assign wr_accept = wr_ram || wr_out0 || wr_out1 || wr_out2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (wr_accept) wr_cnt <= wr_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    dmemresp_rdata = '0;
    if (is_rd) begin
      if (is_mmio) begin
        case (mmio_off)
          OFF_IN0:  dmemresp_rdata = in0_s;
          OFF_IN1:  dmemresp_rdata = in1_s;
          OFF_IN2:  dmemresp_rdata = in2_s;
          OFF_OUT0: dmemresp_rdata = out0;
          OFF_OUT1: dmemresp_rdata = out1;
          OFF_OUT2: dmemresp_rdata = out2;
`ifdef DMEM_MMIO_PERF_EN
          OFF_CCNT: dmemresp_rdata = cyc_cnt;
          OFF_WCNT: dmemresp_rdata = wr_cnt;
`else
          OFF_CCNT: dmemresp_rdata = '0;
          OFF_WCNT: dmemresp_rdata = '0;
`endif
          default:  dmemresp_rdata = '0;
        endcase
      end else begin
        dmemresp_rdata = ram[ram_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

  localparam logic [31:0] B = 32'h0001_0000;
`ifdef DMEM_MMIO_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;
  logic [31:0] in0, in1, in2;
  logic [31:0] out0, out1, out2;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  dmem_mmio_responder #(.ADDR_W(10), .MMIO_BASE(B)) dut (
    .clk           (clk),
    .rst           (rst),
    .dmemreq_val   (dmemreq_val),
    .dmemreq_type  (dmemreq_type),
    .dmemreq_addr  (dmemreq_addr),
    .dmemreq_wdata (dmemreq_wdata),
    .dmemresp_rdata(dmemresp_rdata),
    .in0           (in0),
    .in1           (in1),
    .in2           (in2),
    .out0          (out0),
    .out1          (out1),
    .out2          (out2)
  );

  typedef struct {
    logic        val;
    logic        typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_o0;
    logic [31:0] exp_o1;
    logic [31:0] exp_o2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic t, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] rd,
                              input logic [31:0] o0, input logic [31:0] o1,
                              input logic [31:0] o2);
    vec_t r;
    r.val = v; r.typ = t; r.addr = a; r.wdata = d;
    r.exp_rd = rd; r.exp_o0 = o0; r.exp_o1 = o1; r.exp_o2 = o2;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic t, input logic [31:0] a, input logic [31:0] d);
    dmemreq_val   = v;
    dmemreq_type  = t;
    dmemreq_addr  = a;
    dmemreq_wdata = d;
  endtask

  // Advance to 1 time unit after the next posedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // val typ addr wdata | exp_rd out0 out1 out2
    vecs.push_back(mk(0, 0, 32'h0000_0000, 0,            0,                      0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0000_0100, 0,            0,                      0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 0,                     0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0100, 0,            32'hDEAD_BEEF,          0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0000_1100, 0,            32'hDEAD_BEEF,          0, 0, 0));
    vecs.push_back(mk(1, 0, B + 32'h20,    0,            PERF ? 32'd5 : 32'd0,   0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0102, 0,            32'hDEAD_BEEF,          0, 0, 0));
    vecs.push_back(mk(1, 1, B + 32'h14,    32'hAA,       0,                      0, 0, 0));
    vecs.push_back(mk(1, 0, B + 32'h14,    0,            32'hAA,                 0, 32'hAA, 0));
    vecs.push_back(mk(1, 1, B + 32'h00,    32'd5,        0,                      0, 32'hAA, 0));
    vecs.push_back(mk(1, 0, B + 32'h00,    0,            32'h0BAD_F00D,          0, 32'hAA, 0));
    vecs.push_back(mk(1, 0, B + 32'h40,    0,            0,                      0, 32'hAA, 0));
    vecs.push_back(mk(1, 1, 32'h0000_0200, 32'h1111_1111, 0,                     0, 32'hAA, 0));
    vecs.push_back(mk(1, 1, 32'h0000_0204, 32'h2222_2222, 0,                     0, 32'hAA, 0));
    vecs.push_back(mk(1, 1, B + 32'h10,    32'h55,       0,                      0, 32'hAA, 0));
    vecs.push_back(mk(1, 1, B + 32'h20,    32'd9,        0,                      32'h55, 32'hAA, 0));
    vecs.push_back(mk(1, 0, B + 32'h24,    0,            PERF ? 32'd5 : 32'd0,   32'h55, 32'hAA, 0));
    vecs.push_back(mk(1, 0, B + 32'h20,    0,            PERF ? 32'd17 : 32'd0,  32'h55, 32'hAA, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0200, 0,            32'h1111_1111,          32'h55, 32'hAA, 0));
    vecs.push_back(mk(1, 0, 32'h0000_1204, 0,            32'h2222_2222,          32'h55, 32'hAA, 0));
    vecs.push_back(mk(1, 1, B + 32'h18,    32'h33,       0,                      32'h55, 32'hAA, 0));
    vecs.push_back(mk(1, 0, B + 32'h18,    0,            32'h33,                 32'h55, 32'hAA, 32'h33));
    vecs.push_back(mk(1, 0, B + 32'h08,    0,            0,                      32'h55, 32'hAA, 32'h33));
    vecs.push_back(mk(1, 1, B + 32'h40,    32'hFF,       0,                      32'h55, 32'hAA, 32'h33));
    vecs.push_back(mk(1, 0, B + 32'h24,    0,            PERF ? 32'd6 : 32'd0,   32'h55, 32'hAA, 32'h33));

    rst = 1'b1;
    in0 = 32'h0BAD_F00D;
    in1 = '0;
    in2 = '0;
    drive(0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Table: vector i is applied i cycles after reset release.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].val, vecs[i].typ, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("vec%0d rdata", i), dmemresp_rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d out0", i),  out0, vecs[i].exp_o0);
      check($sformatf("vec%0d out1", i),  out1, vecs[i].exp_o1);
      check($sformatf("vec%0d out2", i),  out2, vecs[i].exp_o2);
      next_cycle();
    end

    // Input synchroniser latency: change in1 at cycle k.
    in1 = 32'h1234_5678;
    drive(1, 0, B + 32'h04, '0);
    @(negedge clk);
    check("sync k", dmemresp_rdata, 32'h0);
    next_cycle();
    @(negedge clk);
    check("sync k+1", dmemresp_rdata, 32'h0);
    next_cycle();
    @(negedge clk);
    check("sync k+2", dmemresp_rdata, 32'h1234_5678);
    next_cycle();

    // Reset mid-stream with a write to out2 pending.
    drive(1, 1, B + 32'h18, 32'd7);
    rst = 1'b1;
    #1;
    check("rst out0", out0, 32'h0);
    check("rst out1", out1, 32'h0);
    check("rst out2", out2, 32'h0);
    next_cycle();
    check("rst out2 hold", out2, 32'h0);
    drive(1, 1, 32'h0000_0100, 32'h1212_1212);
    next_cycle();
    rst = 1'b0;
    drive(1, 0, B + 32'h00, '0);
    @(negedge clk);
    check("post-rst in0 sync", dmemresp_rdata, 32'h0);
    check("post-rst out2", out2, 32'h0);
    next_cycle();
    drive(1, 0, B + 32'h20, '0);
    @(negedge clk);
    check("post-rst ccnt", dmemresp_rdata, PERF ? 32'd1 : 32'd0);
    next_cycle();
    drive(1, 0, B + 32'h24, '0);
    @(negedge clk);
    check("post-rst wcnt", dmemresp_rdata, 32'h0);
    next_cycle();
    drive(1, 0, 32'h0000_0100, '0);
    @(negedge clk);
    check("rst-cycle ram write dropped", dmemresp_rdata, 32'hDEAD_BEEF);
    next_cycle();
    drive(0, 0, 32'h0000_0100, '0);
    @(negedge clk);
    check("idle rdata", dmemresp_rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
